mtl_video_out: RTL and testbench
================================

MTL_VIDEO_OUT -- requirements
Module: mtl_video_out

Interface
REQ-001 SHALL have parameter COLOR_W, default 8, meaning bits per colour channel.
REQ-002 SHALL have parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 800/210/30/16, meaning horizontal region lengths in pixel clocks.
REQ-003 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/22/13/10, meaning vertical region lengths in lines.
REQ-004 SHALL have parameter SYNC_POL, default 0, meaning sync active level (0 = active-low).
REQ-005 clk  in  1  pixel clock; the block uses one clock.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 pix_data  in  3*COLOR_W  pixel as {R,G,B}.
REQ-008 pix_valid / pix_sof  in  1 / 1  beat valid; beat is first pixel of frame.
REQ-009 pix_ready  out  1  beat accepted when pix_valid && pix_ready.
REQ-010 lcd_data  out  3*COLOR_W  panel pixel; lcd_hs, lcd_vs, lcd_de  out  1 each  syncs and data enable.
REQ-011 frame_start  out  1  one-cycle pulse at first active pixel of each frame.
REQ-012 underflow / resync_cnt  out  1 / 8  sticky underflow flag; saturating resync counter.
REQ-013 stat_clr  in  1  clears underflow and resync_cnt.
REQ-014 test_en  in  1  selects internal test pattern (see Configuration).

Function
REQ-015 hcnt SHALL run 0..H_TOTAL-1 (H_TOTAL = sum of H parameters) and wrap to 0; vcnt SHALL increment on hcnt wrap and wrap at V_TOTAL-1.
REQ-016 Region order per line/frame SHALL be active, front porch, sync, back porch; hcnt=0, vcnt=0 is the first active pixel.
REQ-017 Active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE); lcd_de SHALL equal active delayed one clock.
REQ-018 lcd_hs/lcd_vs SHALL be at SYNC_POL during their sync regions, else inverted, delayed one clock to align with lcd_de.
REQ-019 A beat accepted in cycle t SHALL appear on lcd_data in cycle t+1 with lcd_de=1; lcd_data SHALL be 0 when lcd_de=0.
REQ-020 Stream FSM states SHALL be SEEK, HOLD, RUN; reset state SEEK.
REQ-021 SEEK: pix_ready = pix_valid && !pix_sof (non-SOF beats discarded); on pix_valid && pix_sof go to HOLD.
REQ-022 HOLD: pix_ready = 1 only at hcnt=0, vcnt=0; on that acceptance go to RUN.
REQ-023 RUN: pix_ready = active; an accepted beat with pix_sof at a position other than (0,0) SHALL go to HOLD (beat not consumed) and increment resync_cnt.
REQ-024 RUN: accepted beat at (0,0) without pix_sof SHALL go to SEEK and increment resync_cnt.
REQ-025 RUN with active && !pix_valid SHALL output black for that pixel, set underflow, and keep counters running (no stall).
REQ-026 resync_cnt SHALL saturate at 255; stat_clr SHALL clear both status outputs and wins over a simultaneous set event.
REQ-027 frame_start SHALL pulse with lcd_de of pixel (0,0) regardless of FSM state.
REQ-028 In SEEK/HOLD, active pixels SHALL be driven black without setting underflow.

Reset
REQ-029 On reset_n low: hcnt=vcnt=0, FSM=SEEK, lcd_de=0, lcd_data=0, frame_start=0, underflow=0, resync_cnt=0, pix_ready=0, syncs at inactive level (!SYNC_POL).
REQ-030 Reset asserted mid-frame SHALL take effect immediately; after release, timing restarts at (0,0) and the stream must re-present a SOF beat.

Configuration
REQ-031 Macro MTL_VIDEO_OUT_TEST_PATTERN_EN defined: test_en=1 SHALL drive eight equal-width vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black; channels 0 or all-ones) on active pixels, pix_ready=0, FSM forced to SEEK, status outputs unchanged.
REQ-032 Macro undefined: test_en SHALL be ignored and no pattern logic SHALL be present.

Verification
REQ-033 Reset release, pix_valid=0 -> lcd_de first high at cycle 1, line period 1056, frame period 554400 clocks, lcd_hs low for 30 clocks per line starting hcnt=1010.
REQ-034 Continuous source, SOF on first beat -> 384000 beats accepted per frame, lcd_data = beat one cycle later, underflow stays 0.
REQ-035 Drop pix_valid for one cycle at (5,2) in RUN -> pixel (5,2) black, underflow=1, next pixel from stream.
REQ-036 SOF presented at beat 100 of a frame -> FSM to HOLD, resync_cnt=1, SOF beat accepted at next (0,0).
REQ-037 stat_clr and underflow event same cycle -> underflow=0; 300 resyncs -> resync_cnt=255.
REQ-038 With MTL_VIDEO_OUT_TEST_PATTERN_EN, test_en=1 -> pixels 0..99 = FFFFFF, 100..199 = FFFF00, pix_ready=0.

Source files
------------

// File: rtl/mtl_video_out.sv
// Parallel RGB panel timing generator with a SOF-aligned pixel stream input.
// Optional colour-bar generator selected by test_en when MTL_VIDEO_OUT_TEST_PATTERN_EN is defined.
module mtl_video_out #(
  parameter int COLOR_W  = 8,
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 210,
  parameter int H_SYNC   = 30,
  parameter int H_BP     = 16,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 22,
  parameter int V_SYNC   = 13,
  parameter int V_BP     = 10,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [3*COLOR_W-1:0]   pix_data,
  input  logic                   pix_valid,
  input  logic                   pix_sof,
  output logic                   pix_ready,
  output logic [3*COLOR_W-1:0]   lcd_data,
  output logic                   lcd_hs,
  output logic                   lcd_vs,
  output logic                   lcd_de,
  output logic                   frame_start,
  output logic                   underflow,
  output logic [7:0]             resync_cnt,
  input  logic                   stat_clr,
  input  logic                   test_en
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = 3 * COLOR_W;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {SEEK = 2'd0, HOLD = 2'd1, RUN = 2'd2} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [HW-1:0]   r_hcnt;
  logic [VW-1:0]   r_vcnt;
  logic            w_active;
  logic            w_origin;
  logic            w_hsync;
  logic            w_vsync;
  logic            w_tp;
  logic [DW-1:0]   w_bar;
  logic            w_ready;
  logic            w_show;
  logic            w_set_uf;
  logic            w_inc_rs;

  assign w_active = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_origin = (r_hcnt == {HW{1'b0}}) && (r_vcnt == {VW{1'b0}});
  assign w_hsync  = (r_hcnt >= H_SS) && (r_hcnt < H_SE);
  assign w_vsync  = (r_vcnt >= V_SS) && (r_vcnt < V_SE);

`ifdef MTL_VIDEO_OUT_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [HW-1:0] w_bar_q;
  logic [2:0]    w_bar_idx;
  assign w_tp      = test_en;
  assign w_bar_q   = r_hcnt / HW'(BAR_W);
  assign w_bar_idx = (w_bar_q > HW'(7)) ? 3'd7 : w_bar_q[2:0];
  // Bar order white..black maps index bits onto inverted {G=bit2, R=bit1, B=bit0}.
  assign w_bar     = {{COLOR_W{~w_bar_idx[1]}}, {COLOR_W{~w_bar_idx[2]}}, {COLOR_W{~w_bar_idx[0]}}};
`else
  logic w_unused_test_en;
  assign w_tp             = 1'b0;
  assign w_bar            = {DW{1'b0}};
  assign w_unused_test_en = test_en;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hcnt <= {HW{1'b0}};
      r_vcnt <= {VW{1'b0}};
    end else if (r_hcnt == H_LAST) begin
      r_hcnt <= {HW{1'b0}};
      r_vcnt <= (r_vcnt == V_LAST) ? {VW{1'b0}} : r_vcnt + VW'(1);
    end else begin
      r_hcnt <= r_hcnt + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= SEEK;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_tp) begin
      w_state_nxt = SEEK;
    end else begin
      case (r_state)
        SEEK:    if (pix_valid && pix_sof) w_state_nxt = HOLD; else w_state_nxt = SEEK;
        HOLD:    if (pix_valid && w_origin) w_state_nxt = RUN; else w_state_nxt = HOLD;
        RUN: begin
          if (w_active && pix_valid && pix_sof && !w_origin)      w_state_nxt = HOLD;
          else if (w_active && pix_valid && !pix_sof && w_origin) w_state_nxt = SEEK;
          else                                                    w_state_nxt = RUN;
        end
        default: w_state_nxt = SEEK;
      endcase
    end
  end

  // A misplaced SOF in RUN is refused so it stays at the head of the stream for HOLD.
  always_comb begin
    w_ready  = 1'b0;
    w_show   = 1'b0;
    w_set_uf = 1'b0;
    w_inc_rs = 1'b0;
    if (w_tp) begin
      w_ready = 1'b0;
    end else begin
      case (r_state)
        SEEK: w_ready = pix_valid && !pix_sof;
        HOLD: begin
          w_ready = w_origin;
          w_show  = w_origin && pix_valid;
        end
        RUN: begin
          w_ready  = w_active && !(pix_valid && pix_sof && !w_origin);
          w_show   = w_ready && pix_valid;
          w_set_uf = w_active && !pix_valid;
          w_inc_rs = w_active && pix_valid && (pix_sof != w_origin);
        end
        default: w_ready = 1'b0;
      endcase
    end
  end

  assign pix_ready = w_ready && reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_de      <= 1'b0;
      lcd_hs      <= ~SYNC_POL;
      lcd_vs      <= ~SYNC_POL;
      lcd_data    <= {DW{1'b0}};
      frame_start <= 1'b0;
    end else begin
      lcd_de      <= w_active;
      lcd_hs      <= w_hsync ? SYNC_POL : ~SYNC_POL;
      lcd_vs      <= w_vsync ? SYNC_POL : ~SYNC_POL;
      frame_start <= w_origin;
      if (w_tp)        lcd_data <= w_active ? w_bar : {DW{1'b0}};
      else if (w_show) lcd_data <= pix_data;
      else             lcd_data <= {DW{1'b0}};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow  <= 1'b0;
      resync_cnt <= 8'd0;
    end else if (stat_clr) begin
      underflow  <= 1'b0;
      resync_cnt <= 8'd0;
    end else begin
      if (w_set_uf) underflow <= 1'b1;
      if (w_inc_rs && (resync_cnt != 8'hFF)) resync_cnt <= resync_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mtl_video_out.sv
// Scoreboard bench for mtl_video_out on a shrunken 14x7 raster (8x4 active).
module tb_mtl_video_out;
  localparam int CW = 8;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int ST_SEEK = 0, ST_HOLD = 1, ST_RUN = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] pix_data = 24'h0;
  logic        pix_valid = 1'b0, pix_sof = 1'b0, stat_clr = 1'b0, test_en = 1'b0;
  logic        pix_ready, lcd_hs, lcd_vs, lcd_de, frame_start, underflow;
  logic [23:0] lcd_data;
  logic [7:0]  resync_cnt;

  mtl_video_out #(
    .COLOR_W(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_ready(pix_ready), .lcd_data(lcd_data), .lcd_hs(lcd_hs),
    .lcd_vs(lcd_vs), .lcd_de(lcd_de), .frame_start(frame_start), .underflow(underflow),
    .resync_cnt(resync_cnt), .stat_clr(stat_clr), .test_en(test_en)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        de, hs, vs, fs, uf;
    logic [7:0]  rs;
    logic [23:0] data;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0, errors = 0;
  bit   mon_en = 1'b0;
  int   bh = 0, bv = 0, exp_st = ST_SEEK, m_rs = 0;
  logic m_uf = 1'b0;
  int   beat = 0, next_sof = 0;

  function automatic logic [23:0] beat_data(input int b);
    return 24'h5A0000 ^ b[23:0];
  endfunction

  function automatic logic [23:0] bar_color(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Monitor: every clock the panel presents one pixel slot; compare it with the queued expectation.
  always @(posedge clk) begin
    #1;
    if (mon_en && sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      checks += 3;
      if ({lcd_de, lcd_hs, lcd_vs, frame_start} !== {mon_e.de, mon_e.hs, mon_e.vs, mon_e.fs}) begin
        errors++;
        $display("FAIL timing t=%0t de/hs/vs/fs got=%b required=%b", $time,
                 {lcd_de, lcd_hs, lcd_vs, frame_start}, {mon_e.de, mon_e.hs, mon_e.vs, mon_e.fs});
      end
      if (lcd_data !== mon_e.data) begin
        errors++;
        $display("FAIL lcd_data t=%0t got=%h required=%h", $time, lcd_data, mon_e.data);
      end
      if ({underflow, resync_cnt} !== {mon_e.uf, mon_e.rs}) begin
        errors++;
        $display("FAIL status t=%0t uf/rs got=%b/%0d required=%b/%0d", $time,
                 underflow, resync_cnt, mon_e.uf, mon_e.rs);
      end
    end
  end

  // One pixel clock: drive inputs, predict the response from the stream rules, check pix_ready.
  task automatic step(input logic v, input logic s, input logic [23:0] d,
                      input logic clr, input logic tp, output logic acc);
    logic act, org, rdy, uf_set, rs_inc;
    logic [23:0] pix;
    int nxt;
    exp_t e;
    act = (bh < HA) && (bv < VA);
    org = (bh == 0) && (bv == 0);
    rdy = 1'b0; pix = 24'h0; nxt = exp_st; uf_set = 1'b0; rs_inc = 1'b0;
    if (tp) begin
      nxt = ST_SEEK;
      pix = act ? bar_color(bh) : 24'h0;
    end else if (exp_st == ST_SEEK) begin
      rdy = v && !s;
      if (v && s) nxt = ST_HOLD;
    end else if (exp_st == ST_HOLD) begin
      rdy = org;
      if (v && org) begin pix = d; nxt = ST_RUN; end
    end else begin
      if (!act) begin
        rdy = 1'b0;
      end else if (!v) begin
        rdy = 1'b1; uf_set = 1'b1;
      end else if (s && !org) begin
        nxt = ST_HOLD; rs_inc = 1'b1;
      end else begin
        rdy = 1'b1; pix = d;
        if (!s && org) begin nxt = ST_SEEK; rs_inc = 1'b1; end
      end
    end
    acc = v && rdy;
    if (clr) begin
      m_uf = 1'b0; m_rs = 0;
    end else begin
      if (uf_set) m_uf = 1'b1;
      if (rs_inc && m_rs < 255) m_rs++;
    end
    exp_st = nxt;
    e.de = act; e.fs = org; e.uf = m_uf; e.rs = m_rs[7:0]; e.data = pix;
    e.hs = !((bh >= HA + HF) && (bh < HA + HF + HS));
    e.vs = !((bv >= VA + VF) && (bv < VA + VF + VS));
    pix_valid = v; pix_sof = s; pix_data = d; stat_clr = clr; test_en = tp;
    sbq.push_back(e);
    #1;
    checks++;
    if (pix_ready !== rdy) begin
      errors++;
      $display("FAIL pix_ready pos=(%0d,%0d) got=%b required=%b", bh, bv, pix_ready, rdy);
    end
    @(posedge clk);
    if (bh == HT - 1) begin bh = 0; bv = (bv == VT - 1) ? 0 : bv + 1; end
    else bh = bh + 1;
    @(negedge clk);
  endtask

  task automatic src_step(input logic drop, input logic clr);
    logic a, s;
    s = (beat == next_sof);
    step(!drop, s, beat_data(beat), clr, 1'b0, a);
    if (a) begin
      if (s) next_sof = beat + 32;
      beat++;
    end
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) src_step(1'b0, 1'b0);
  endtask

  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    while (!(bh == h && bv == v) && n < 2 * HT * VT) begin
      src_step(1'b0, 1'b0);
      n++;
    end
  endtask

  // Assert reset with a live source and check that outputs drop at once, then restart at (0,0).
  task automatic do_reset();
    mon_en = 1'b0;
    pix_valid = 1'b1; pix_sof = 1'b0; stat_clr = 1'b0; test_en = 1'b0;
    reset_n = 1'b0;
    #1;
    checks += 3;
    if ({lcd_de, frame_start, lcd_hs, lcd_vs, lcd_data} !== {4'b0011, 24'h0}) begin
      errors++;
      $display("FAIL reset_out got de/fs/hs/vs=%b data=%h required=0011 data=000000",
               {lcd_de, frame_start, lcd_hs, lcd_vs}, lcd_data);
    end
    if ({underflow, resync_cnt} !== 9'h0) begin
      errors++;
      $display("FAIL reset_status got uf=%b rs=%0d required uf=0 rs=0", underflow, resync_cnt);
    end
    if (pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got=%b required=0", pix_ready);
    end
    sbq.delete();
    repeat (3) @(negedge clk);
    pix_valid = 1'b0;
    reset_n = 1'b1;
    bh = 0; bv = 0; exp_st = ST_SEEK; m_uf = 1'b0; m_rs = 0;
    mon_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    @(negedge clk);
    do_reset();
    // Idle raster: timing only, nothing accepted.
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, a);
    // Junk beats discarded, SOF held, then continuous frames.
    beat = 0; next_sof = 3;
    run_n(300);
    // Single-cycle starvation at (5,2).
    run_to(5, 2); src_step(1'b1, 1'b0); run_n(50);
    // Clear colliding with a new underflow event.
    run_to(5, 2); src_step(1'b1, 1'b1); run_n(10);
    // Early SOF mid-frame.
    run_to(0, 1); next_sof = beat + 10; run_n(200);
    // Missing SOF at the frame origin.
    run_to(0, 3); next_sof = beat + 40; run_n(300);
    // Drive the resync counter into saturation.
    for (int k = 0; k < 300; k++) begin
      run_to(0, 1);
      next_sof = beat + 3;
      src_step(1'b0, 1'b0);
    end
    run_n(20); src_step(1'b0, 1'b1); run_n(20);
    run_to(0, 1); next_sof = beat + 3; run_n(40);
    // Reset while pixels are streaming.
    run_to(4, 2);
    do_reset();
    next_sof = beat + 5;
    run_n(250);
`ifdef MTL_VIDEO_OUT_TEST_PATTERN_EN
    for (int i = 0; i < HT * VT + 5; i++) step(1'b1, 1'b0, beat_data(beat), 1'b0, 1'b1, a);
    next_sof = beat + 5;
    run_n(250);
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending required=0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
